// File: rtl/zx_kbd_pkg.sv
// zx_kbd_pkg: shared constants, flag bit positions and receiver state
// encoding for the ZX-Spectrum serial keyboard-matrix receiver.
package zx_kbd_pkg;

    localparam int FRAME_BITS  = 48;
    localparam int MATRIX_BITS = 40;
    localparam int KBD_ROWS    = 8;
    localparam int KBD_COLS    = 5;

    // Bit positions inside KBD_FLAGS (frame bits [47:40]).
    localparam int FLAG_MAGIC     = 0;
    localparam int FLAG_TURBO     = 1;
    localparam int FLAG_PNT       = 2;
    localparam int FLAG_RESET_REQ = 3;

    // Bit counter saturates one past a full frame so that any overlong
    // frame stays distinguishable from a good one.
    localparam int CNT_SAT = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } kbd_state_t;

endpackage

// File: rtl/zx_kbd_spi_sync.sv
// kbd_sync: multi-stage synchroniser for one asynchronous input with
// rise/fall detection. Edges are suppressed until the chain has refilled
// after reset, so a level that was already present at reset release is
// never reported as an edge.
module kbd_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic CLK_14MHZ,
    input  logic RESET,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic [SYNC_STAGES:0]   armed;

    // Synchroniser chain, one-cycle history for edge detect, and arming shift.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            armed <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous value of its neighbour; blocking ones would collapse
            // the chain into a single flop.
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
            armed <= {armed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    assign rise     = armed[SYNC_STAGES] &  sync_out & ~prev;
    assign fall     = armed[SYNC_STAGES] & ~sync_out &  prev;

endmodule

// File: rtl/zx_kbd_spi.sv
// zx_kbd_spi: receives 48-bit keyboard frames (8 flag bits + 8x5 key
// matrix, MSB first) over KBD_CLK/KBD_CS/KBD_DI and drives the active-low
// KD[4:0] column field of port #FE from the selected rows in A_HI.
// Optional build macro: KBD_TIMEOUT_EN -- releases all keys after
// TIMEOUT_CYCLES clocks without a valid frame.
module zx_kbd_spi
    import zx_kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1400000
) (
    input  logic       CLK_14MHZ,
    input  logic       RESET,
    input  logic       KBD_CLK,
    input  logic       KBD_CS,
    input  logic       KBD_DI,
    input  logic [7:0] A_HI,
    output logic [4:0] KD,
    output logic [7:0] KBD_FLAGS,
    output logic       FRAME_VALID,
    output logic       FRAME_ERR
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("zx_kbd_spi: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 21)) begin : g_bad_timeout
        $error("zx_kbd_spi: TIMEOUT_CYCLES must fit the 21-bit timeout counter");
    end

    logic clk_rise;
    logic clk_unused_level;
    logic clk_unused_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;

    kbd_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .CLK_14MHZ (CLK_14MHZ),
        .RESET     (RESET),
        .async_in  (KBD_CLK),
        .sync_out  (clk_unused_level),
        .rise      (clk_rise),
        .fall      (clk_unused_fall)
    );

    kbd_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .CLK_14MHZ (CLK_14MHZ),
        .RESET     (RESET),
        .async_in  (KBD_CS),
        .sync_out  (cs_level),
        .rise      (cs_rise),
        .fall      (cs_fall)
    );

    logic [SYNC_STAGES-1:0] di_chain;
    logic                   di_sync;

    // Data line only needs level synchronisation, same depth as KBD_CLK.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) di_chain <= '0;
        else       di_chain <= {di_chain[SYNC_STAGES-2:0], KBD_DI};
    end
    assign di_sync = di_chain[SYNC_STAGES-1];

    kbd_state_t            state;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [MATRIX_BITS-1:0] matrix;

    logic                  shift_en;
    logic [5:0]            cnt_upd;
    logic [FRAME_BITS-1:0] shreg_upd;
    logic                  load_frame;
    logic                  timeout_hit;

    // Shift/count first so a CS rise in the same cycle commits the updated count.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        cnt_upd   = bit_cnt;
        shreg_upd = shreg;
        shift_en  = (state == SHIFT) && clk_rise;
        if (shift_en) begin
            shreg_upd = {shreg[FRAME_BITS-2:0], di_sync};
            if (bit_cnt < 6'(CNT_SAT)) cnt_upd = bit_cnt + 6'd1;
        end
        load_frame = (state == SHIFT) && cs_rise && (cnt_upd == 6'(FRAME_BITS));
    end

`ifdef KBD_TIMEOUT_EN
    localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] to_cnt;

    // Idle timer: restarts on every committed frame, saturates at the limit.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET)                 to_cnt <= '0;
        else if (load_frame)       to_cnt <= '0;
        else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 21'd1;
    end
    assign timeout_hit = (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame receive FSM with registered commit/error pulses and key state.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            // NOTE: the matrix is only 40 flops and its reset value is
            // architecturally visible (all keys released), so it is reset.
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            matrix      <= '0;
            KBD_FLAGS   <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt <= cnt_upd;
                    shreg   <= shreg_upd;
                    if (cs_rise) begin
                        state       <= COMMIT;
                        FRAME_VALID <= load_frame;
                        FRAME_ERR   <= ~load_frame;
                    end
                end
                COMMIT: begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    state   <= cs_level ? IDLE : SHIFT;
                end
                default: state <= IDLE;
            endcase

            if (load_frame) begin
                {KBD_FLAGS, matrix} <= shreg_upd;
            end else if (timeout_hit) begin
                KBD_FLAGS <= '0;
                matrix    <= '0;
            end
        end
    end

    logic [KBD_COLS-1:0] col_hit;

    // A column reads low if any selected row has that key pressed.
    always_comb begin
        col_hit = '0;
        for (int r = 0; r < KBD_ROWS; r++) begin
            for (int c = 0; c < KBD_COLS; c++) begin
                col_hit[c] = col_hit[c] | (matrix[r*KBD_COLS + c] & ~A_HI[r]);
            end
        end
    end

    // Registered active-low column output for port #FE reads.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) KD <= '1;
        else       KD <= ~col_hit;
    end

endmodule
